// File: rtl/seq_control.sv
// seq_control: compare-and-write sequencer for the register-file/ALU datapath.
//
// Walks every adjacent register pair (k, k+1), k = 0..NREG-2. For each pair it
// sets up the operand muxes (SETUP), samples the datapath flag mayor (CMP),
// and either halts at that pair or writes both registers (WR0, WR1). A full
// sweep over all pairs is one pass. With MAX_PASS=0 it sweeps forever; with
// MAX_PASS=N it stops in DONE after N passes.
//
// Handshake: start is a level request. It is looked at only in IDLE, DONE
// and HALT. Leaving DONE/HALT needs start=0 for at least one cycle. Every
// new run begins at pair 0 with the pass count cleared.
//
// Optional feature macro: CTRL_STEP_EN. When it is defined, every transition
// out of SETUP/CMP/WR0/WR1 waits for a cycle with step=1. When it is not
// defined, step is ignored.
//
// Ports:
//   clk        clock; all state updates happen on its rising edge
//   rst        synchronous active-high reset
//   start      run request level
//   mayor      datapath compare flag; sampled only in CMP
//   step       single-step advance; used only when CTRL_STEP_EN is defined
//   o_alu_op   ALU operation
//   o_sel_a    mux A select (k)
//   o_sel_b    mux B select (k+1)
//   o_sel_reg  write destination select
//   o_we       register write enable
//   o_busy     high in SETUP/CMP/WR0/WR1
//   o_done     high in DONE
//   o_halted   high in HALT
//   o_pair     current pair index k
//   o_pass     count of completed passes
//   dbg_state  raw FSM state, for debug visibility
//
// Every output is decoded from registered state only, so no input has a
// combinational path to an output.
module seq_control #(
  parameter int NREG     = 4,
  parameter int SEL_W    = 2,
  parameter int ALU_W    = 3,
  parameter int ALU_CMP  = 0,
  parameter int ALU_OP0  = 1,
  parameter int ALU_OP1  = 2,
  parameter int MAX_PASS = 0,
  parameter int PASS_W   = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              mayor,
  input  logic              step,
  output logic [ALU_W-1:0]  o_alu_op,
  output logic [SEL_W-1:0]  o_sel_a,
  output logic [SEL_W-1:0]  o_sel_b,
  output logic [SEL_W-1:0]  o_sel_reg,
  output logic              o_we,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_halted,
  output logic [SEL_W-1:0]  o_pair,
  output logic [PASS_W-1:0] o_pass,
  output logic [2:0]        dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SETUP = 3'd1,
    S_CMP   = 3'd2,
    S_WR0   = 3'd3,
    S_WR1   = 3'd4,
    S_HALT  = 3'd5,
    S_DONE  = 3'd6
  } state_t;

  localparam logic [SEL_W-1:0]  LAST_K = SEL_W'(NREG - 2);
  localparam logic [PASS_W-1:0] MAX_P  = PASS_W'(MAX_PASS);
  localparam logic [ALU_W-1:0]  OP_CMP = ALU_W'(ALU_CMP);
  localparam logic [ALU_W-1:0]  OP_0   = ALU_W'(ALU_OP0);
  localparam logic [ALU_W-1:0]  OP_1   = ALU_W'(ALU_OP1);

  state_t            state, state_n;
  logic [SEL_W-1:0]  k, k_n, k_plus1;
  logic [PASS_W-1:0] pass, pass_n, pass_inc;
  logic              adv;

`ifdef CTRL_STEP_EN
  assign adv = step;
`else
  logic unused_step;
  assign unused_step = step;
  assign adv         = 1'b1;
`endif

  assign k_plus1  = k + 1'b1;
  assign pass_inc = pass + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      k     <= '0;
      pass  <= '0;
    end else begin
      state <= state_n;
      k     <= k_n;
      pass  <= pass_n;
    end
  end

  // Next-state logic. Only the busy states are gated by adv.
  // IDLE, HALT and DONE react to start alone.
  always_comb begin
    state_n = state;
    k_n     = k;
    pass_n  = pass;
    case (state)
      S_IDLE: begin
        if (start) begin
          state_n = S_SETUP;
          k_n     = '0;
          pass_n  = '0;
        end
      end
      S_SETUP: if (adv) state_n = S_CMP;
      S_CMP: begin
        if (adv) state_n = mayor ? S_HALT : S_WR0;
      end
      S_WR0: if (adv) state_n = S_WR1;
      S_WR1: begin
        if (adv) begin
          if (k != LAST_K) begin
            k_n     = k_plus1;
            state_n = S_SETUP;
          end else begin
            pass_n = pass_inc;
            // On the final pass, k stays at the last pair so o_pair shows
            // where the run ended.
            if (MAX_PASS != 0 && pass_inc == MAX_P) begin
              state_n = S_DONE;
            end else begin
              k_n     = '0;
              state_n = S_SETUP;
            end
          end
        end
      end
      S_HALT: if (!start) state_n = S_IDLE;
      S_DONE: if (!start) state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  // Moore output decode.
  always_comb begin
    o_alu_op  = '0;
    o_sel_a   = '0;
    o_sel_b   = '0;
    o_sel_reg = '0;
    o_we      = 1'b0;
    o_busy    = 1'b0;
    o_done    = 1'b0;
    o_halted  = 1'b0;
    o_pair    = k;
    o_pass    = pass;
    dbg_state = state;
    case (state)
      S_SETUP, S_CMP: begin
        o_alu_op = OP_CMP;
        o_sel_a  = k;
        o_sel_b  = k_plus1;
        o_busy   = 1'b1;
      end
      S_WR0: begin
        o_alu_op  = OP_0;
        o_sel_a   = k;
        o_sel_b   = k_plus1;
        o_sel_reg = k;
        o_we      = 1'b1;
        o_busy    = 1'b1;
      end
      S_WR1: begin
        o_alu_op  = OP_1;
        o_sel_a   = k;
        o_sel_b   = k_plus1;
        o_sel_reg = k_plus1;
        o_we      = 1'b1;
        o_busy    = 1'b1;
      end
      S_HALT:  o_halted = 1'b1;
      S_DONE:  o_done   = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_seq_control.sv
// Testbench for seq_control. It runs two instances, one free-running
// (MAX_PASS=0) and one limited (MAX_PASS=1), with shared stimulus.
//
// The reference model treats a run as a cycle count t measured from the
// first busy cycle:
//   pair  = (t/4) mod (NREG-1)
//   phase = t mod 4
//   pass  = t / (4*(NREG-1))
// Predicted writes go into per-instance queues. A monitor checks each write
// pulse against the front of its queue.
module tb_seq_control;

  localparam int NREG     = 4;
  localparam int PASS_CYC = 4 * (NREG - 1);
  localparam int NCYC     = 3000;
  localparam int W        = 9;  // {sel_reg, alu_op, sel_a, sel_b}

  localparam int M_IDLE = 0;
  localparam int M_RUN  = 1;
  localparam int M_HALT = 2;
  localparam int M_DONE = 3;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, start, mayor, step;

  logic [2:0] alu[2];
  logic [1:0] sa[2], sb[2], sr[2], pair[2];
  logic       we[2], busy[2], done[2], halted[2];
  logic [7:0] pass[2];
  logic [2:0] dbg[2];

  seq_control #(.NREG(NREG), .MAX_PASS(0)) u_free (
    .clk(clk), .rst(rst), .start(start), .mayor(mayor), .step(step),
    .o_alu_op(alu[0]), .o_sel_a(sa[0]), .o_sel_b(sb[0]), .o_sel_reg(sr[0]),
    .o_we(we[0]), .o_busy(busy[0]), .o_done(done[0]), .o_halted(halted[0]),
    .o_pair(pair[0]), .o_pass(pass[0]), .dbg_state(dbg[0])
  );

  seq_control #(.NREG(NREG), .MAX_PASS(1)) u_lim (
    .clk(clk), .rst(rst), .start(start), .mayor(mayor), .step(step),
    .o_alu_op(alu[1]), .o_sel_a(sa[1]), .o_sel_b(sb[1]), .o_sel_reg(sr[1]),
    .o_we(we[1]), .o_busy(busy[1]), .o_done(done[1]), .o_halted(halted[1]),
    .o_pair(pair[1]), .o_pass(pass[1]), .dbg_state(dbg[1])
  );

  // scoreboard state
  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  logic [W-1:0] exp_q0[$];
  logic [W-1:0] exp_q1[$];

  // reference model state
  int m_mode[2];
  int m_t[2];
  int m_k[2];
  int m_pass[2];
  int lim[2];

  task automatic chk(input string name, input int u, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s unit%0d cycle %0d: got %0d expected %0d",
               name, u, cyc, act, exp);
    end
  endtask

  // Expected write word for the model's current cycle (valid in phase 2/3).
  function automatic logic [W-1:0] exp_word(input int u);
    int k, p;
    logic [1:0] e_sr, e_sa, e_sb;
    logic [2:0] e_alu;
    k     = (m_t[u] / 4) % (NREG - 1);
    p     = m_t[u] % 4;
    e_sa  = 2'(k);
    e_sb  = 2'(k + 1);
    e_sr  = (p == 2) ? 2'(k) : 2'(k + 1);
    e_alu = (p == 2) ? 3'd1 : 3'd2;
    return {e_sr, e_alu, e_sa, e_sb};
  endfunction

  task automatic check_unit(input int u);
    int k, p;
    logic [31:0] e_alu, e_sa, e_sb, e_sr, e_we, e_busy, e_done, e_halt;
    logic [31:0] e_pair, e_pass;
    e_alu = 0; e_sa = 0; e_sb = 0; e_sr = 0; e_we = 0;
    e_busy = 0; e_done = 0; e_halt = 0;
    e_pair = m_k[u]; e_pass = m_pass[u];
    if (m_mode[u] == M_RUN) begin
      k      = (m_t[u] / 4) % (NREG - 1);
      p      = m_t[u] % 4;
      e_pair = k;
      e_pass = (m_t[u] / PASS_CYC) % 256;
      e_busy = 1;
      e_sa   = k;
      e_sb   = k + 1;
      if (p == 2) begin e_alu = 1; e_sr = k;     e_we = 1; end
      if (p == 3) begin e_alu = 2; e_sr = k + 1; e_we = 1; end
    end else if (m_mode[u] == M_HALT) begin
      e_halt = 1;
    end else if (m_mode[u] == M_DONE) begin
      e_done = 1;
    end
    chk("alu_op",  u, 32'(alu[u]),    e_alu);
    chk("sel_a",   u, 32'(sa[u]),     e_sa);
    chk("sel_b",   u, 32'(sb[u]),     e_sb);
    chk("sel_reg", u, 32'(sr[u]),     e_sr);
    chk("we",      u, 32'(we[u]),     e_we);
    chk("busy",    u, 32'(busy[u]),   e_busy);
    chk("done",    u, 32'(done[u]),   e_done);
    chk("halted",  u, 32'(halted[u]), e_halt);
    chk("pair",    u, 32'(pair[u]),   e_pair);
    chk("pass",    u, 32'(pass[u]),   e_pass);
  endtask

  task automatic model_step(input int u, input bit r, input bit s,
                            input bit my, input bit adv);
    if (r) begin
      m_mode[u] = M_IDLE;
      m_k[u]    = 0;
      m_pass[u] = 0;
    end else begin
      case (m_mode[u])
        M_IDLE: if (s) begin m_mode[u] = M_RUN; m_t[u] = 0; end
        M_RUN: begin
          if (adv) begin
            if (m_t[u] % 4 == 1 && my) begin
              m_mode[u] = M_HALT;
              m_k[u]    = (m_t[u] / 4) % (NREG - 1);
              m_pass[u] = (m_t[u] / PASS_CYC) % 256;
            end else begin
              m_t[u]++;
              if (lim[u] != 0 && m_t[u] == PASS_CYC * lim[u]) begin
                m_mode[u] = M_DONE;
                m_k[u]    = NREG - 2;
                m_pass[u] = lim[u];
              end
            end
          end
        end
        default: if (!s) m_mode[u] = M_IDLE;
      endcase
    end
  endtask

  // Driver task: apply one cycle of inputs and advance the model.
  // Queue an expected write when the next cycle is a write phase.
  task automatic drive(input bit r, input bit s, input bit my, input bit st);
    bit adv;
    rst = r; start = s; mayor = my; step = st;
    adv = 1'b1;
`ifdef CTRL_STEP_EN
    adv = st;
`endif
    for (int u = 0; u < 2; u++) begin
      model_step(u, r, s, my, adv);
      if (m_mode[u] == M_RUN && m_t[u] % 4 >= 2) begin
        if (u == 0) exp_q0.push_back(exp_word(0));
        else        exp_q1.push_back(exp_word(1));
      end
    end
  endtask

  // Write monitors: pop and compare on every write pulse.
  always @(negedge clk) begin
    if (we[0] === 1'b1) begin
      if (exp_q0.size() == 0) chk("write_unexpected", 0, 1, 0);
      else chk("write", 0, 32'({sr[0], alu[0], sa[0], sb[0]}), 32'(exp_q0.pop_front()));
    end
  end

  always @(negedge clk) begin
    if (we[1] === 1'b1) begin
      if (exp_q1.size() == 0) chk("write_unexpected", 1, 1, 0);
      else chk("write", 1, 32'({sr[1], alu[1], sa[1], sb[1]}), 32'(exp_q1.pop_front()));
    end
  end

  // Main stimulus
  initial begin
    lim[0] = 0; lim[1] = 1;
    for (int u = 0; u < 2; u++) begin
      m_mode[u] = M_IDLE; m_t[u] = 0; m_k[u] = 0; m_pass[u] = 0;
    end
    drive(1'b1, 1'b1, 1'b0, 1'b1);
    for (int c = 0; c < NCYC; c++) begin
      @(negedge clk);
      cyc = c;
      check_unit(0);
      check_unit(1);
      if (c < 2) begin
        // Reset held with start high.
        drive(1'b1, 1'b1, 1'b0, 1'b1);
      end else if (c < 60) begin
        // Long run with mayor low: pair wrap, pass counting, limited DONE.
        drive(1'b0, 1'b1, 1'b0, 1'b1);
      end else if (c == 60) begin
        // Reset pulse in the middle of a run, start still high.
        drive(1'b1, 1'b1, 1'b0, 1'b1);
      end else begin
        drive(1'($urandom_range(0, 149) == 0),
              1'($urandom_range(0, 9) != 0),
              1'($urandom_range(0, 11) == 0),
              1'($urandom_range(0, 3) != 0));
      end
    end
    @(negedge clk);
    #1;
    chk("queue_drained", 0, 32'(exp_q0.size()), 0);
    chk("queue_drained", 1, 32'(exp_q1.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/seq_control.md
Name: seq_control

Overview:
- Parametrised compare-and-write sequencer that drives the register-file/ALU datapath through all adjacent register pairs (k, k+1), k = 0..NREG-2.
- For each pair it sets up the operand muxes, samples the datapath comparison flag `mayor`, and either halts or issues two register writes.
- Successor to the fixed 3-pair controller. Adds:
  - parametrised register count and field widths;
  - start/done level handshake;
  - pass counting with an optional pass limit;
  - status outputs.

Parameters:
- NREG, 4, number of datapath registers; legal 2..16.
- SEL_W, 2, width of mux/register select fields; must be >= clog2(NREG).
- ALU_W, 3, width of ALU operation field.
- ALU_CMP, 0, ALU op driven during SETUP/CMP.
- ALU_OP0, 1, ALU op driven during WR0.
- ALU_OP1, 2, ALU op driven during WR1.
- MAX_PASS, 0, passes before DONE; 0 = unbounded, wrap to pair 0 forever.
- PASS_W, 8, pass counter width.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- rst  in  1  synchronous active-high reset.
- start  in  1  level request; sampled in IDLE, DONE and HALT.
- mayor  in  1  datapath compare flag; sampled only in CMP.
- step  in  1  single-step advance; used only with CTRL_STEP_EN.
- o_alu_op  out  ALU_W  ALU operation.
- o_sel_a  out  SEL_W  mux A select.
- o_sel_b  out  SEL_W  mux B select.
- o_sel_reg  out  SEL_W  write destination select.
- o_we  out  1  register write enable.
- o_busy  out  1  high in SETUP/CMP/WR0/WR1.
- o_done  out  1  high in DONE.
- o_halted  out  1  high in HALT.
- o_pair  out  SEL_W  current pair index k.
- o_pass  out  PASS_W  completed pass count.

Behaviour:
Reset and output timing:
- rst=1 at a clock edge: state=IDLE, k=0, pass=0.
- All outputs are 0 from the cycle after that edge; this applies at any point, including mid-write.
- Outputs are Moore-decoded from registered state, k and pass; no input-to-output combinational path.

States:
- IDLE: all controls 0. start=1 -> SETUP with k=0, pass=0; else stay.
- SETUP: alu_op=ALU_CMP, sel_a=k, sel_b=k+1, sel_reg=0, we=0. -> CMP.
- CMP: same controls as SETUP. mayor=1 -> HALT; else -> WR0.
- WR0: alu_op=ALU_OP0, sel_a=k, sel_b=k+1, sel_reg=k, we=1. -> WR1.
- WR1: alu_op=ALU_OP1, sel_a=k, sel_b=k+1, sel_reg=k+1, we=1.
  - k<NREG-2: k<=k+1, -> SETUP.
  - k==NREG-2: pass<=pass+1. If MAX_PASS!=0 and pass+1==MAX_PASS -> DONE, k held. Otherwise k<=0, -> SETUP.
- HALT: controls 0, o_halted=1, k frozen at the offending pair. start=0 -> IDLE; else stay.
- DONE: controls 0, o_done=1. start=0 -> IDLE; else stay.
- Undefined state encodings -> IDLE.

Timing and boundary conditions:
- Each pair takes 4 cycles; a full pass takes 4*(NREG-1) cycles.
- First write occurs in the 3rd cycle after start is seen in IDLE.
- pass wraps modulo 2^PASS_W when MAX_PASS=0.
- A pass that halts is not counted.
- mayor outside CMP is ignored.
- start changes outside IDLE/DONE/HALT are ignored; an operation cannot be aborted except by rst.
- NREG=2: a single pair; k stays 0.
- Leaving HALT/DONE requires start=0 for at least one cycle (4-phase handshake); the next run starts from k=0, pass=0.

Optional Feature:
CTRL_STEP_EN:
- Defined: each transition out of SETUP, CMP, WR0 and WR1 happens only on a cycle with step=1; otherwise the state, k and pass hold.
  - o_we stays asserted while WR0/WR1 is held; the datapath writes the same value repeatedly, which is harmless.
  - mayor is sampled on the CMP cycle where step=1.
  - IDLE/DONE/HALT transitions ignore step.
- Undefined: step is ignored and free-run behaviour applies.

Test Plan:
All scenarios use NREG=4 and default parameters unless stated.
1. Reset: rst=1 for 2 cycles with start=1 -> every output 0, o_busy=0; rst released -> SETUP next cycle.
2. MAX_PASS=1, mayor=0, start=1 -> o_we high for 6 cycles total.
   - (sel_reg, alu_op) sequence: (0,1), (1,2), (1,1), (2,2), (2,1), (3,2).
   - o_done=1 on the 13th cycle after leaving IDLE, with o_pass=1.
3. mayor=1 during CMP of pair 1 -> HALT next cycle, o_halted=1, o_pair=1, exactly 2 write pulses seen; drop start -> IDLE.
4. MAX_PASS=0, mayor=0 for 40 cycles -> o_pair sequence 0,1,2,0,...; o_pass increments every 12 cycles; 3 at cycle 36.
5. rst pulse during WR0 of pair 2 -> o_we=0 next cycle, o_pass=0; with start still 1 -> restarts at pair 0.
6. CTRL_STEP_EN defined: step=0 for 5 cycles in CMP -> outputs frozen; a single step=1 pulse -> advance exactly one state.
